// File: rtl/seven_segment_scan_scheduler.sv
// Four-digit multiplexed 7-segment scan scheduler.
// Each digit is lit for DWELL_CYCLES clocks. New display content is loaded
// through a req/ack handshake, and only at a frame wrap, so a frame never
// shows a mix of old and new digits.
// Optional feature: define SSD_LEADING_ZERO_BLANK_EN to blank leading zeros
// in digits 3..1. Digit 0 is never blanked.
module seven_segment_scan_scheduler #(
  parameter int unsigned DWELL_CYCLES = 1,
  parameter int unsigned DW_W         = 4
) (
  input  logic        clk_1kHz,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic        upd_req,
  output logic        upd_ack,
  output logic        frame_tick,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;

  // Reject parameter values that cannot work, at elaboration time.
  if (DWELL_CYCLES == 0) begin : g_bad_dwell
    $error("seven_segment_scan_scheduler: DWELL_CYCLES must be >= 1");
  end
  if ((64'd1 << DW_W) < 64'(DWELL_CYCLES)) begin : g_bad_dw_w
    $error("seven_segment_scan_scheduler: DW_W too narrow for DWELL_CYCLES");
  end

  logic [DW_W-1:0]  dwell;
  logic [IDX_W-1:0] idx;
  logic [15:0]      shadow;

  logic             advance_c;
  logic             wrap_c;
  logic [3:0]       en_eff_c;
  logic [NIB_W-1:0] nib_c;
  logic [SEG_W-1:0] glyph_c;

  // Scan timing: decide whether this edge advances the digit and/or ends the frame.
  always_comb begin
    advance_c = (dwell == DW_W'(DWELL_CYCLES - 1));
    wrap_c    = advance_c && (idx == IDX_W'(3));
  end

  // Effective per-digit enable: live digit_en, optionally masked by leading-zero blanking.
  always_comb begin
    en_eff_c = digit_en;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    if (shadow[15:12] == 4'h0) en_eff_c[3] = 1'b0;
    if (shadow[15:8]  == 8'h0) en_eff_c[2] = 1'b0;
    if (shadow[15:4]  == 12'h0) en_eff_c[1] = 1'b0;
`endif
  end

  // Select the current digit's nibble from the shadow copy.
  always_comb begin
    nib_c = shadow[{idx, 2'b00} +: NIB_W];
  end

  // Active-low hex glyph decode, segment order {g,f,e,d,c,b,a}.
  always_comb begin
    glyph_c = 7'b1111111;
    case (nib_c)
      4'h0: glyph_c = 7'b1000000;
      4'h1: glyph_c = 7'b1111001;
      4'h2: glyph_c = 7'b0100100;
      4'h3: glyph_c = 7'b0110000;
      4'h4: glyph_c = 7'b0011001;
      4'h5: glyph_c = 7'b0010010;
      4'h6: glyph_c = 7'b0000010;
      4'h7: glyph_c = 7'b1111000;
      4'h8: glyph_c = 7'b0000000;
      4'h9: glyph_c = 7'b0010000;
      4'hA: glyph_c = 7'b0001000;
      4'hB: glyph_c = 7'b0000011;
      4'hC: glyph_c = 7'b1000110;
      4'hD: glyph_c = 7'b0100001;
      4'hE: glyph_c = 7'b0000110;
      4'hF: glyph_c = 7'b0001110;
      default: glyph_c = 7'b1111111;
    endcase
  end

  // Scan state, shadow register and registered display/handshake outputs.
  always_ff @(posedge clk_1kHz or posedge rst) begin
    if (rst) begin
      dwell      <= '0;
      idx        <= '0;
      shadow     <= '0;
      seg        <= 7'b1111111;
      an         <= 4'b1111;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (advance_c) begin
        dwell <= '0;
        idx   <= idx + IDX_W'(1);
      end else begin
        dwell <= dwell + DW_W'(1);
      end

      if (en_eff_c[idx]) begin
        an  <= ~(4'b0001 << idx);
        seg <= glyph_c;
      end else begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
      end

      frame_tick <= wrap_c;
      upd_ack    <= wrap_c && upd_req;
      if (wrap_c && upd_req) begin
        shadow <= digits;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_scheduler.sv
// Bench for seven_segment_scan_scheduler: a cycle-indexed behavioural model
// plus directed literal checks and a randomized phase.
// Define SSD_LEADING_ZERO_BLANK_EN for both bench and RTL to cover leading-zero blanking.
module tb_seven_segment_scan_scheduler;

  localparam int unsigned D     = 3;
  localparam int unsigned DWW   = 4;
  localparam int unsigned FRAME = 4 * D;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] LIT_AN  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] LIT_SEG [4] = '{7'b1000000, 7'b1111001, 7'b0001000, 7'b0000000};
  localparam logic [3:0] BLK_AN  [4] = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};

  logic        clk_1kHz;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic        upd_req;
  logic        upd_ack;
  logic        frame_tick;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_err = 0;

  seven_segment_scan_scheduler #(.DWELL_CYCLES(D), .DW_W(DWW)) dut (
    .clk_1kHz  (clk_1kHz),
    .rst       (rst),
    .digits    (digits),
    .digit_en  (digit_en),
    .upd_req   (upd_req),
    .upd_ack   (upd_ack),
    .frame_tick(frame_tick),
    .seg       (seg),
    .an        (an)
  );

  initial clk_1kHz = 1'b0;
  always #5 clk_1kHz = ~clk_1kHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: edges counted from reset release; digit index and
  // wrap position follow from plain division by the dwell length.
  int          n_edge = 0;
  logic [15:0] m_shadow = '0;
  int          m_idx;
  bit          m_wrap;
  logic [3:0]  m_en;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_ack;
  logic        e_tick;
  logic [15:0] m_next;

  always @(posedge clk_1kHz) begin
    if (rst) begin
      n_edge   = 0;
      m_shadow = '0;
    end else begin
      m_idx  = (n_edge / D) % 4;
      m_wrap = (n_edge % FRAME) == FRAME - 1;
      m_en   = digit_en;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      for (int k = 1; k < 4; k++) begin
        if ((m_shadow >> (4 * k)) == 16'd0) m_en[k] = 1'b0;
      end
`endif
      e_an   = m_en[m_idx] ? (4'hF ^ 4'(1 << m_idx)) : 4'hF;
      e_seg  = m_en[m_idx] ? GLYPH[4'((m_shadow >> (4 * m_idx)) & 16'hF)] : 7'h7F;
      e_tick = m_wrap;
      e_ack  = m_wrap && upd_req;
      m_next = e_ack ? digits : m_shadow;
      #1;
      if (!rst) begin
        check("model_an", 32'(an), 32'(e_an));
        check("model_seg", 32'(seg), 32'(e_seg));
        check("model_tick", 32'(frame_tick), 32'(e_tick));
        check("model_ack", 32'(upd_ack), 32'(e_ack));
      end
      m_shadow = m_next;
      n_edge++;
    end
  end

  // Wait (bounded) for a negedge at which frame_tick is high.
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk_1kHz);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    check("wait_frame_tick", 32'(seen), 32'd1);
  endtask

  // Request/acknowledge load of new display content (bounded).
  task automatic load(input logic [15:0] v);
    bit seen = 1'b0;
    @(negedge clk_1kHz);
    digits  = v;
    upd_req = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk_1kHz);
      if (upd_ack) begin
        seen = 1'b1;
        break;
      end
    end
    upd_req = 1'b0;
    check("load_ack", 32'(seen), 32'd1);
  endtask

  int ack_cnt;
  int tick_gap;

  initial begin
    rst      = 1'b1;
    digits   = '0;
    digit_en = 4'hF;
    upd_req  = 1'b0;
    #3;
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_an", 32'(an), 32'hF);
    check("reset_ack", 32'(upd_ack), 32'd0);
    check("reset_tick", 32'(frame_tick), 32'd0);
    @(negedge clk_1kHz);
    @(negedge clk_1kHz);
    rst = 1'b0;
    @(negedge clk_1kHz);
    check("first_an", 32'(an), 32'b1110);
    check("first_seg", 32'(seg), 32'b1000000);

    // frame_tick period
    wait_tick();
    tick_gap = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk_1kHz);
      tick_gap++;
      if (frame_tick) break;
    end
    check("tick_period", 32'(tick_gap), 32'(FRAME));

    // Update 8A10 requested while digit 1 is active
    repeat (D) @(negedge clk_1kHz);
    load(16'h8A10);
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < int'(D); d++) begin
        @(negedge clk_1kHz);
        check("upd_frame_an", 32'(an), 32'(LIT_AN[k]));
        check("upd_frame_seg", 32'(seg), 32'(LIT_SEG[k]));
      end
    end

    // Blanking via digit_en
    digit_en = 4'b0101;
    wait_tick();
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < int'(D); d++) begin
        @(negedge clk_1kHz);
        check("blank_an", 32'(an), 32'(BLK_AN[k]));
        if (BLK_AN[k] == 4'hF) check("blank_seg", 32'(seg), 32'h7F);
      end
    end
    digit_en = 4'hF;

    // Request dropped before the wrap: no ack
    wait_tick();
    digits  = 16'h1234;
    upd_req = 1'b1;
    repeat (2) @(negedge clk_1kHz);
    upd_req = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge clk_1kHz);
      if (upd_ack) ack_cnt++;
    end
    check("dropped_req_acks", 32'(ack_cnt), 32'd0);

    // Request raised on the wrap cycle itself
    wait_tick();
    repeat (FRAME - 1) @(negedge clk_1kHz);
    digits  = 16'hC0DE;
    upd_req = 1'b1;
    @(negedge clk_1kHz);
    check("wrap_cycle_ack", 32'(upd_ack), 32'd1);
    upd_req = 1'b0;
    @(negedge clk_1kHz);
    check("wrap_cycle_seg", 32'(seg), 32'(GLYPH[4'hE]));

    // Asynchronous reset mid-scan
    repeat (5) @(negedge clk_1kHz);
    #2 rst = 1'b1;
    #1;
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_ack", 32'(upd_ack), 32'd0);
    @(negedge clk_1kHz);
    @(negedge clk_1kHz);
    rst = 1'b0;
    @(negedge clk_1kHz);
    check("midrst_first_an", 32'(an), 32'b1110);
    check("midrst_first_seg", 32'(seg), 32'b1000000);

`ifdef SSD_LEADING_ZERO_BLANK_EN
    load(16'h0030);
    wait_tick();
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge clk_1kHz);
      check("lzb_30_an_hi", 32'(an[3:2]), 32'b11);
      if (i / D == 1) check("lzb_30_seg1", 32'(seg), 32'(GLYPH[3]));
      if (i / D == 0) check("lzb_30_seg0", 32'(seg), 32'(GLYPH[0]));
    end
    load(16'h0000);
    wait_tick();
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge clk_1kHz);
      check("lzb_0_an", 32'(an), (i / D == 0) ? 32'b1110 : 32'b1111);
    end
`endif

    // Randomized phase: live enables, random requests, sometimes held past ack
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_1kHz);
      digit_en = 4'($urandom);
      if (!upd_req) begin
        if ($urandom_range(0, 7) == 0) begin
          digits  = 16'($urandom);
          upd_req = 1'b1;
        end
      end else if ((upd_ack && $urandom_range(0, 1) == 0) || $urandom_range(0, 15) == 0) begin
        upd_req = 1'b0;
      end
    end
    upd_req = 1'b0;
    repeat (3) @(negedge clk_1kHz);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
